nmcu_stream: RTL and testbench



---
 rtl/nmcu_stream.sv | 177 +++++++++++++++++
 tb/tb_nmcu_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_stream.sv
// Streaming 2-D convolution unit: captures a tile and kernel, then produces one
// MAC tap per cycle and hands each output over a valid/ready port. NMCU_RELU_EN clamps negative results to zero.
module nmcu_stream #(
  parameter int A_SIZE      = 4,
  parameter int KERNEL_SIZE = 2,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 32,
  localparam int OUT_SIZE   = (A_SIZE + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int IDX_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      ready,
  input  logic [A_SIZE*A_SIZE*WIDTH-1:0]            A,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*WIDTH-1:0]  kernel,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ACC_WIDTH-1:0]                      out_data,
  output logic [IDX_W-1:0]                          out_row,
  output logic [IDX_W-1:0]                          out_col,
  output logic                                      done,
  output logic [1:0]                                dbg_state
);

  // Output handshake: a result transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops and out_data/out_row/out_col never change until that transfer.
  localparam int NTAP   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TAP_W  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int KW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int NELEM  = A_SIZE * A_SIZE;
  localparam int AIDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]     a_mem [NELEM];
  logic signed [WIDTH-1:0]     k_mem [NTAP];
  logic signed [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0]        out_data_q;
  logic [IDX_W-1:0]            orow, ocol;
  logic [KW-1:0]               kr, kc;
  logic [TAP_W-1:0]            tap;
  logic                        done_q;

  logic                        last_tap, last_out, in_range;
  logic signed [31:0]          ir, ic;
  logic [AIDX_W-1:0]           a_idx;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, sum, result;

  assign last_tap = (tap == TAP_W'(NTAP - 1));
  assign last_out = (orow == IDX_W'(OUT_SIZE - 1)) && (ocol == IDX_W'(OUT_SIZE - 1));

  // Map the current tap onto the unpadded tile; padding taps contribute nothing.
  always_comb begin
    ir       = int'(orow) * STRIDE + int'(kr) - PADDING;
    ic       = int'(ocol) * STRIDE + int'(kc) - PADDING;
    in_range = (ir >= 0) && (ir < A_SIZE) && (ic >= 0) && (ic < A_SIZE);
    a_idx    = in_range ? AIDX_W'(ir * A_SIZE + ic) : '0;
    prod     = a_mem[a_idx] * k_mem[tap];
    prod_ext = ACC_WIDTH'(prod);
    sum      = in_range ? (acc + prod_ext) : acc;
`ifdef NMCU_RELU_EN
    result   = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    result   = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_next = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = last_out ? S_IDLE : S_MAC;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture happens only on job acceptance, so the job is immune to later input changes.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      for (int i = 0; i < NELEM; i++) a_mem[i] <= A[i*WIDTH +: WIDTH];
      for (int i = 0; i < NTAP; i++)  k_mem[i] <= kernel[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      out_data_q <= '0;
      orow       <= '0;
      ocol       <= '0;
      kr         <= '0;
      kc         <= '0;
      tap        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= '0;
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
            tap  <= '0;
          end
        end
        S_MAC: begin
          acc <= sum;
          if (last_tap) begin
            tap        <= '0;
            kr         <= '0;
            kc         <= '0;
            out_data_q <= result;
          end else begin
            tap <= tap + 1'b1;
            if (kc == KW'(KERNEL_SIZE - 1)) begin
              kc <= '0;
              kr <= kr + 1'b1;
            end else begin
              kc <= kc + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc <= '0;
            if (last_out) begin
              orow   <= '0;
              ocol   <= '0;
              done_q <= 1'b1;
            end else if (ocol == IDX_W'(OUT_SIZE - 1)) begin
              ocol <= '0;
              orow <= orow + 1'b1;
            end else begin
              ocol <= ocol + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = orow;
  assign out_col   = ocol;
  assign done      = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_nmcu_stream.sv
// Randomized self-checking bench for nmcu_stream: default build plus a padded/strided instance,
// each checked against a direct convolution model.
module tb_nmcu_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, start2, out_ready, out_ready2;
  logic [127:0] a_flat;
  logic [31:0]  k_flat;

  logic         ready, out_valid, done;
  logic [31:0]  out_data;
  logic [1:0]   out_row, out_col, dbg_state;
  logic         ready2, out_valid2, done2;
  logic [31:0]  out_data2;
  logic [1:0]   out_row2, out_col2, dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];

  nmcu_stream u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .A(a_flat), .kernel(k_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .done(done), .dbg_state(dbg_state)
  );

  nmcu_stream #(.PADDING(1), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .ready(ready2),
    .A(a_flat), .kernel(k_flat), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_row(out_row2), .out_col(out_col2),
    .done(done2), .dbg_state(dbg_state2)
  );

  // Reference: direct sum over kernel taps for every output position, row-major.
  task automatic build_model(input int pad, input int stride);
    int osz, sum, iy, ix;
    logic signed [7:0] av, kv;
    osz = (4 + 2*pad - 2) / stride + 1;
    exp_q.delete();
    for (int oy = 0; oy < osz; oy++) begin
      for (int ox = 0; ox < osz; ox++) begin
        sum = 0;
        for (int ky = 0; ky < 2; ky++) begin
          for (int kx = 0; kx < 2; kx++) begin
            iy = oy*stride + ky - pad;
            ix = ox*stride + kx - pad;
            if (iy >= 0 && iy < 4 && ix >= 0 && ix < 4) begin
              av  = a_flat[(iy*4 + ix)*8 +: 8];
              kv  = k_flat[(ky*2 + kx)*8 +: 8];
              sum = sum + av * kv;
            end
          end
        end
`ifdef NMCU_RELU_EN
        if (sum < 0) sum = 0;
`endif
        exp_q.push_back({sum, 2'(oy), 2'(ox)});
      end
    end
  endtask

  // rmode: 0 always ready, 1 random ready, 2 each result held off for 5 cycles.
  task automatic run_job(input int sel, input int rmode, input bit mid_start, input bit check_lat);
    int k, first_k, done_k, wait_cnt, accepted;
    logic v, dn, rdy, rdy_in;
    logic [31:0] d;
    logic [1:0] r, c;
    bit fin;
    build_model(sel ? 1 : 0, sel ? 2 : 1);
    accepted = 0; first_k = -1; done_k = -1; wait_cnt = 0; fin = 0;
    @(negedge clk);
    rdy = sel ? ready2 : ready;
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++; $display("FAIL job_ready: got %b expected 1", rdy);
    end
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0; k = 1;
    while (!fin && k < 600) begin
      v   = sel ? out_valid2 : out_valid;
      dn  = sel ? done2 : done;
      d   = sel ? out_data2 : out_data;
      r   = sel ? out_row2 : out_row;
      c   = sel ? out_col2 : out_col;
      rdy = sel ? ready2 : ready;
      case (rmode)
        0:       rdy_in = 1'b1;
        1:       rdy_in = 1'($urandom_range(0, 1));
        default: rdy_in = (wait_cnt >= 5);
      endcase
      if (sel) out_ready2 = rdy_in; else out_ready = rdy_in;
      if (v && first_k < 0) first_k = k;
      if (v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_result: got data=%0d row=%0d col=%0d expected none", $signed(d), r, c);
        end else if ({d, r, c} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL result: got data=%0d row=%0d col=%0d expected data=%0d row=%0d col=%0d",
                   $signed(d), r, c, $signed(exp_q[0][35:4]), exp_q[0][3:2], exp_q[0][1:0]);
        end
        if (rdy_in) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          accepted++; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (dn) begin
        done_k = k; fin = 1;
        n_checks++;
        if (exp_q.size() != 0 || rdy !== 1'b1 || v !== 1'b0) begin
          n_fail++; $display("FAIL done_cycle: got pending=%0d ready=%b valid=%b expected 0/1/0", exp_q.size(), rdy, v);
        end
      end
      if (mid_start && k == 7) begin
        a_flat = {$urandom, $urandom, $urandom, $urandom};
        k_flat = $urandom;
        if (sel) start2 = 1'b1; else start = 1'b1;
      end else begin
        start = 1'b0; start2 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; start2 = 1'b0;
    n_checks++;
    if (!fin) begin
      n_fail++; $display("FAIL timeout: got no done after %0d cycles expected done", k);
    end
    n_checks++;
    if (accepted != 9) begin
      n_fail++; $display("FAIL result_count: got %0d expected 9", accepted);
    end
    dn = sel ? done2 : done;
    n_checks++;
    if (dn !== 1'b0) begin
      n_fail++; $display("FAIL done_width: got %b one cycle later expected 0", dn);
    end
    if (check_lat) begin
      n_checks++;
      if (first_k != 5 || done_k != 46) begin
        n_fail++; $display("FAIL latency: got first_valid=c+%0d done=c+%0d expected c+5 c+46", first_k, done_k);
      end
    end
    out_ready = 1'b1; out_ready2 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    a_flat = '0; k_flat = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, out_valid, done, out_data, out_row, out_col} !== {1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 2'd0}) begin
      n_fail++; $display("FAIL reset_state: got ready=%b valid=%b done=%b data=%0d row=%0d col=%0d expected 1 0 0 0 0 0",
                         ready, out_valid, done, out_data, out_row, out_col);
    end
    n_checks++;
    if ({ready2, out_valid2, done2, out_data2} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL reset_state2: got ready=%b valid=%b done=%b data=%0d expected 1 0 0 0",
                         ready2, out_valid2, done2, out_data2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    a_flat = {16{8'h01}};
    k_flat = {4{8'h02}};
    run_job(0, 0, 0, 1);
  endtask

  task automatic test_diag();
    for (int i = 0; i < 16; i++) a_flat[i*8 +: 8] = 8'(i);
    k_flat = {8'd1, 8'd0, 8'd0, 8'd1};
    run_job(0, 0, 0, 0);
  endtask

  task automatic test_pad_stride();
    for (int i = 0; i < 16; i++) a_flat[i*8 +: 8] = 8'(i);
    k_flat = {8'd1, 8'd0, 8'd0, 8'd1};
    run_job(1, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    a_flat = {$urandom, $urandom, $urandom, $urandom};
    k_flat = $urandom;
    run_job(0, 2, 1, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      a_flat = {$urandom, $urandom, $urandom, $urandom};
      k_flat = $urandom;
      run_job(j % 2, 1, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 2; j++) begin
      a_flat = {$urandom, $urandom, $urandom, $urandom};
      k_flat = $urandom;
      run_job(0, 0, 0, 0);
    end
  endtask

  task automatic test_negative();
    a_flat = {16{8'hFF}};
    k_flat = {4{8'h01}};
    run_job(0, 0, 0, 0);
  endtask

  task automatic test_abort();
    int bad;
    a_flat = {$urandom, $urandom, $urandom, $urandom};
    k_flat = $urandom;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({ready, out_valid, done, out_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL abort_state: got ready=%b valid=%b done=%b data=%0d expected 1 0 0 0",
                         ready, out_valid, done, out_data);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_diag();
    test_pad_stride();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_negative();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
